// File: rtl/npu_host_slave.sv
// Host bus responder for the NPU: decodes buffer/PARA/OP regions and runs the op-launch FSM.
// Optional build macro NPU_PERF_CNT_EN adds a busy-cycle counter readable at PARA 0x24.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | no op in flight, STATUS=0
// ST_OS_RUN | OS tile computation launched, waiting os_done_i
// ST_MV_RUN | OS-to-ACT move launched, waiting mv_done_i
// ST_DONE   | op finished, STATUS=2 until host clears or relaunches
module npu_host_slave #(
    parameter int DWidth       = 32,
    parameter int RAM_AW       = 10,
    parameter int REGION_SHIFT = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cen_i,
    input  logic              wen_i,
    input  logic [DWidth-1:0] addr_i,
    input  logic [DWidth-1:0] wdata_i,
    output logic [DWidth-1:0] rdata_o,
    output logic [3:0]        buf_cen_o,
    output logic              buf_wen_o,
    output logic [RAM_AW-1:0] buf_addr_o,
    output logic [DWidth-1:0] buf_wdata_o,
    input  logic [DWidth-1:0] imem_rdata_i,
    input  logic [DWidth-1:0] wmem_rdata_i,
    input  logic [DWidth-1:0] bmem_rdata_i,
    input  logic [DWidth-1:0] omem_rdata_i,
    output logic [DWidth-1:0] a_base_o,
    output logic [DWidth-1:0] a_rows_o,
    output logic [DWidth-1:0] w_base_o,
    output logic [DWidth-1:0] w_cols_o,
    output logic [DWidth-1:0] o_base_o,
    output logic [DWidth-1:0] intra_o_base_o,
    output logic [DWidth-1:0] intra_a_base_o,
    output logic              os_start_o,
    output logic              mv_start_o,
    input  logic              os_done_i,
    input  logic              mv_done_i
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OS_RUN = 2'd1;
    localparam logic [1:0] ST_MV_RUN = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [2:0] SEL_PARA = 3'd4;
    localparam logic [2:0] SEL_OP   = 3'd5;

    localparam logic [REGION_SHIFT-1:0] OFF_00 = 'h00;
    localparam logic [REGION_SHIFT-1:0] OFF_04 = 'h04;
    localparam logic [REGION_SHIFT-1:0] OFF_08 = 'h08;
    localparam logic [REGION_SHIFT-1:0] OFF_0C = 'h0C;
    localparam logic [REGION_SHIFT-1:0] OFF_10 = 'h10;
    localparam logic [REGION_SHIFT-1:0] OFF_14 = 'h14;
    localparam logic [REGION_SHIFT-1:0] OFF_18 = 'h18;
    localparam logic [REGION_SHIFT-1:0] OFF_1C = 'h1C;
    localparam logic [REGION_SHIFT-1:0] OFF_20 = 'h20;
    localparam logic [REGION_SHIFT-1:0] OFF_24 = 'h24;

    logic [1:0]              state;
    logic [2:0]              sel;
    logic [REGION_SHIFT-1:0] off;
    logic                    is_buf, wr, rd, busy;
    logic                    para_wr, op_os, op_mv, launch, status_clr, done_any;
    logic [DWidth-1:0]       status_val, perf_val, para_rd, buf_mux;
    logic                    rd_pend_q;
    logic [1:0]              rd_sel_q;
    logic [DWidth-1:0]       rdata_q;
    logic                    unused_addr_hi;

    assign sel            = addr_i[REGION_SHIFT+2:REGION_SHIFT];
    assign off            = addr_i[REGION_SHIFT-1:0];
    assign unused_addr_hi = ^addr_i[DWidth-1:REGION_SHIFT+3];
    assign is_buf         = ~sel[2];
    assign wr             = cen_i & wen_i;
    assign rd             = cen_i & ~wen_i;
    assign busy           = (state == ST_OS_RUN) || (state == ST_MV_RUN);
    assign done_any       = os_done_i | mv_done_i;

    assign para_wr    = wr && (sel == SEL_PARA) && !busy;
    assign op_os      = wr && (sel == SEL_OP) && (off == OFF_00) && wdata_i[0];
    assign op_mv      = wr && (sel == SEL_OP) && (off == OFF_04) && wdata_i[0];
    assign launch     = (op_os || op_mv) && !busy;
    assign status_clr = para_wr && (off == OFF_04) && (wdata_i == '0);

    // Buffer writes are fenced off while an op owns the buffers; reads still pass.
    always_comb begin
        buf_cen_o = '0;
        if (rst_ni && cen_i && is_buf && !(wen_i && busy))
            buf_cen_o[sel[1:0]] = 1'b1;
    end
    assign buf_wen_o   = wen_i;
    assign buf_addr_o  = addr_i[RAM_AW+1:2];
    assign buf_wdata_o = wdata_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= ST_IDLE;
            os_start_o <= 1'b0;
            mv_start_o <= 1'b0;
        end else begin
            os_start_o <= 1'b0;
            mv_start_o <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (op_os) begin
                        state      <= ST_OS_RUN;
                        os_start_o <= 1'b1;
                    end else if (op_mv) begin
                        state      <= ST_MV_RUN;
                        mv_start_o <= 1'b1;
                    end else if (state == ST_DONE && status_clr && !done_any) begin
                        state <= ST_IDLE;
                    end
                end
                ST_OS_RUN: if (os_done_i) state <= ST_DONE;
                ST_MV_RUN: if (mv_done_i) state <= ST_DONE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_base_o       <= '0;
            a_rows_o       <= '0;
            w_base_o       <= '0;
            w_cols_o       <= '0;
            o_base_o       <= '0;
            intra_o_base_o <= '0;
            intra_a_base_o <= '0;
        end else if (para_wr) begin
            case (off)
                OFF_08:  a_base_o       <= wdata_i;
                OFF_0C:  a_rows_o       <= wdata_i;
                OFF_10:  w_base_o       <= wdata_i;
                OFF_14:  w_cols_o       <= wdata_i;
                OFF_18:  o_base_o       <= wdata_i;
                OFF_1C:  intra_o_base_o <= wdata_i;
                OFF_20:  intra_a_base_o <= wdata_i;
                default: ;
            endcase
        end
    end

`ifdef NPU_PERF_CNT_EN
    logic [DWidth-1:0] perf_cnt;
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            perf_cnt <= '0;
        else if (launch)
            perf_cnt <= '0;
        else if (busy && perf_cnt != '1)
            perf_cnt <= perf_cnt + DWidth'(1);
    end
    assign perf_val = perf_cnt;
`else
    assign perf_val = '0;
`endif

    assign status_val = busy ? DWidth'(1) : ((state == ST_DONE) ? DWidth'(2) : '0);

    always_comb begin
        para_rd = '0;
        case (off)
            OFF_04:  para_rd = status_val;
            OFF_08:  para_rd = a_base_o;
            OFF_0C:  para_rd = a_rows_o;
            OFF_10:  para_rd = w_base_o;
            OFF_14:  para_rd = w_cols_o;
            OFF_18:  para_rd = o_base_o;
            OFF_1C:  para_rd = intra_o_base_o;
            OFF_20:  para_rd = intra_a_base_o;
            OFF_24:  para_rd = perf_val;
            default: para_rd = '0;
        endcase
    end

    always_comb begin
        case (rd_sel_q)
            2'd0:    buf_mux = imem_rdata_i;
            2'd1:    buf_mux = wmem_rdata_i;
            2'd2:    buf_mux = bmem_rdata_i;
            default: buf_mux = omem_rdata_i;
        endcase
    end

    // Buffer RAM data only arrives in the cycle after the request, so it is
    // forwarded that cycle and captured into rdata_q to be held afterwards.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_pend_q <= 1'b0;
            rd_sel_q  <= 2'd0;
            rdata_q   <= '0;
        end else begin
            if (rd_pend_q)
                rdata_q <= buf_mux;
            if (rd && !is_buf)
                rdata_q <= (sel == SEL_PARA) ? para_rd : '0;
            if (rd && is_buf)
                rd_sel_q <= sel[1:0];
            rd_pend_q <= rd && is_buf;
        end
    end

    assign rdata_o = rd_pend_q ? buf_mux : rdata_q;

endmodule

// File: tb/tb_npu_host_slave.sv
// Randomized self-checking bench for npu_host_slave against a transaction-level model.
// Honours NPU_PERF_CNT_EN when computing expected PARA 0x24 reads.
module tb_npu_host_slave;

    logic        clk_i = 1'b0;
    logic        rst_ni, cen_i, wen_i, os_done_i, mv_done_i;
    logic [31:0] addr_i, wdata_i, rdata_o, buf_wdata_o;
    logic [3:0]  buf_cen_o;
    logic        buf_wen_o, os_start_o, mv_start_o;
    logic [9:0]  buf_addr_o;
    logic [31:0] imem_rdata_i, wmem_rdata_i, bmem_rdata_i, omem_rdata_i;
    logic [31:0] a_base_o, a_rows_o, w_base_o, w_cols_o, o_base_o, intra_o_base_o, intra_a_base_o;
    logic [31:0] par_o [7];

    always #5 clk_i = ~clk_i;

    npu_host_slave dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cen_i(cen_i), .wen_i(wen_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
        .buf_cen_o(buf_cen_o), .buf_wen_o(buf_wen_o), .buf_addr_o(buf_addr_o),
        .buf_wdata_o(buf_wdata_o),
        .imem_rdata_i(imem_rdata_i), .wmem_rdata_i(wmem_rdata_i),
        .bmem_rdata_i(bmem_rdata_i), .omem_rdata_i(omem_rdata_i),
        .a_base_o(a_base_o), .a_rows_o(a_rows_o), .w_base_o(w_base_o), .w_cols_o(w_cols_o),
        .o_base_o(o_base_o), .intra_o_base_o(intra_o_base_o), .intra_a_base_o(intra_a_base_o),
        .os_start_o(os_start_o), .mv_start_o(mv_start_o),
        .os_done_i(os_done_i), .mv_done_i(mv_done_i)
    );

    assign par_o[0] = a_base_o;
    assign par_o[1] = a_rows_o;
    assign par_o[2] = w_base_o;
    assign par_o[3] = w_cols_o;
    assign par_o[4] = o_base_o;
    assign par_o[5] = intra_o_base_o;
    assign par_o[6] = intra_a_base_o;

    // Synchronous buffer RAMs driven only by the DUT's buffer port.
    logic [31:0] ram [4][1024];
    logic [31:0] ram_q [4];
    always @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (buf_cen_o[i]) begin
                if (buf_wen_o) ram[i][buf_addr_o] <= buf_wdata_o;
                else           ram_q[i] <= ram[i][buf_addr_o];
            end
        end
    end
    assign imem_rdata_i = ram_q[0];
    assign wmem_rdata_i = ram_q[1];
    assign bmem_rdata_i = ram_q[2];
    assign omem_rdata_i = ram_q[3];

    // Reference model: status 0 idle / 1 busy / 2 done, kind 0 OS / 1 move.
    logic [31:0] m_mem [4][1024];
    logic [31:0] m_par [7];
    logic [31:0] m_rd, m_perf;
    int          m_status, m_kind;
    int          total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [2:0]  s;
        logic [11:0] o;
        s = a[14:12];
        o = a[11:0];
        if (s < 3'd4) return m_mem[s[1:0]][a[11:2]];
        if (s != 3'd4) return 32'd0;
        if (o == 12'h004) return 32'(m_status);
        if (o >= 12'h008 && o <= 12'h020 && o[1:0] == 2'b00) return m_par[(o - 12'h008) >> 2];
`ifdef NPU_PERF_CNT_EN
        if (o == 12'h024) return m_perf;
`endif
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_status = 0;
        m_kind   = 0;
        m_rd     = 0;
        m_perf   = 0;
        for (int i = 0; i < 7; i++) m_par[i] = 0;
    endtask

    // One bus cycle: drive at negedge, check combinational decode, then check
    // registered outputs just after the rising edge.
    task automatic cyc(input logic c, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic osd, input logic mvd);
        logic [2:0]  s;
        logic [11:0] o;
        logic [3:0]  exp_cen;
        logic        exp_os, exp_mv, lau;
        int          pre;
        @(negedge clk_i);
        cen_i = c; wen_i = w; addr_i = a; wdata_i = d; os_done_i = osd; mv_done_i = mvd;
        s = a[14:12];
        o = a[11:0];
        pre = m_status;
        exp_cen = 4'b0;
        if (c && s < 3'd4 && !(w && pre == 1)) exp_cen = 4'b1 << s[1:0];
        #1;
        chk("buf_cen", {28'b0, buf_cen_o}, {28'b0, exp_cen});
        if (exp_cen != 4'b0) begin
            chk("buf_addr", {22'b0, buf_addr_o}, {22'b0, a[11:2]});
            if (w) chk("buf_wdata", buf_wdata_o, d);
        end
        if (c && !w) m_rd = model_read(a);
        if (c && w && pre != 1) begin
            if (s < 3'd4) m_mem[s[1:0]][a[11:2]] = d;
            if (s == 3'd4 && o >= 12'h008 && o <= 12'h020 && o[1:0] == 2'b00)
                m_par[(o - 12'h008) >> 2] = d;
        end
        if (pre == 1 && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
        lau = c && w && s == 3'd5 && d[0] && pre != 1 && (o == 12'h000 || o == 12'h004);
        exp_os = lau && o == 12'h000;
        exp_mv = lau && o == 12'h004;
        if (lau) begin
            m_status = 1;
            m_kind   = exp_os ? 0 : 1;
            m_perf   = 0;
        end else if (pre == 1 && ((m_kind == 0 && osd) || (m_kind == 1 && mvd))) begin
            m_status = 2;
        end else if (pre == 2 && c && w && s == 3'd4 && o == 12'h004 && d == 0 && !(osd || mvd)) begin
            m_status = 0;
        end
        @(posedge clk_i);
        #1;
        chk("rdata", rdata_o, m_rd);
        chk("os_start", {31'b0, os_start_o}, {31'b0, exp_os});
        chk("mv_start", {31'b0, mv_start_o}, {31'b0, exp_mv});
        for (int i = 0; i < 7; i++) chk($sformatf("param%0d", i), par_o[i], m_par[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        cen_i = 1'b1; wen_i = 1'b1; addr_i = 32'h0; wdata_i = 32'hDEAD_BEEF;
        os_done_i = 1'b0; mv_done_i = 1'b0;
        #1 chk("rst_buf_cen", {28'b0, buf_cen_o}, 32'd0);
        @(posedge clk_i);
        #1;
        model_reset();
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_os_start", {31'b0, os_start_o}, 32'd0);
        chk("rst_mv_start", {31'b0, mv_start_o}, 32'd0);
        for (int i = 0; i < 7; i++) chk($sformatf("rst_param%0d", i), par_o[i], 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cen_i = 1'b0; wen_i = 1'b0;
    endtask

    initial begin
        logic [31:0] a, d;
        logic        osd, mvd;
        int          r;
        rst_ni = 1'b1; cen_i = 0; wen_i = 0; addr_i = 0; wdata_i = 0; os_done_i = 0; mv_done_i = 0;
        for (int i = 0; i < 4; i++) begin
            ram_q[i] = 0;
            for (int j = 0; j < 1024; j++) begin
                ram[i][j]   = 0;
                m_mem[i][j] = 0;
            end
        end
        model_reset();
        do_reset();
        idle(1);

        cyc(1, 0, 32'h4004, 0, 0, 0);
        chk("reset_status", rdata_o, 32'd0);
        cyc(1, 0, 32'h4008, 0, 0, 0);
        chk("reset_a_base", rdata_o, 32'd0);

        cyc(1, 1, 32'h0040, 32'd10, 0, 0);
        cyc(1, 0, 32'h0040, 0, 0, 0);
        chk("imem_rd", rdata_o, 32'd10);

        cyc(1, 1, 32'h400C, 32'd15, 0, 0);
        cyc(1, 1, 32'h4014, 32'd15, 0, 0);
        cyc(1, 1, 32'h5000, 32'd1, 0, 0);
        chk("os_pulse", {31'b0, os_start_o}, 32'd1);
        cyc(1, 0, 32'h4004, 0, 0, 0);
        chk("os_pulse_gone", {31'b0, os_start_o}, 32'd0);
        chk("status_busy", rdata_o, 32'd1);
        cyc(1, 1, 32'h1008, 32'd5, 0, 0);
        cyc(1, 1, 32'h4008, 32'd7, 0, 0);
        cyc(1, 1, 32'h5004, 32'd1, 0, 0);
        chk("no_mv_pulse", {31'b0, mv_start_o}, 32'd0);
        idle(15);
        cyc(0, 0, 32'h0, 0, 1, 0);
        cyc(1, 0, 32'h4024, 0, 0, 0);
`ifdef NPU_PERF_CNT_EN
        chk("perf_cnt", rdata_o, 32'd20);
`else
        chk("perf_cnt", rdata_o, 32'd0);
`endif
        cyc(1, 0, 32'h4004, 0, 0, 0);
        chk("status_done", rdata_o, 32'd2);
        cyc(1, 0, 32'h1008, 0, 0, 0);
        chk("wmem_blocked", rdata_o, 32'd0);
        cyc(1, 0, 32'h4008, 0, 0, 0);
        chk("a_base_blocked", rdata_o, 32'd0);
        cyc(1, 1, 32'h4004, 32'd0, 0, 0);
        cyc(1, 0, 32'h4004, 0, 0, 0);
        chk("status_clear", rdata_o, 32'd0);

        cyc(1, 1, 32'h5000, 32'd1, 0, 0);
        idle(3);
        cyc(0, 0, 32'h0, 0, 0, 1);
        cyc(0, 0, 32'h0, 0, 1, 0);
        cyc(1, 1, 32'h5004, 32'd1, 0, 0);
        chk("mv_pulse_from_done", {31'b0, mv_start_o}, 32'd1);
        cyc(1, 0, 32'h4004, 0, 0, 0);
        chk("status_mv_busy", rdata_o, 32'd1);
        do_reset();
        cyc(1, 0, 32'h4004, 0, 0, 0);
        chk("status_after_rst", rdata_o, 32'd0);
        cyc(1, 0, 32'h400C, 0, 0, 0);
        chk("a_rows_after_rst", rdata_o, 32'd0);

        for (int n = 0; n < 800; n++) begin
            r   = $urandom_range(0, 9);
            osd = ($urandom_range(0, 7) == 0);
            mvd = ($urandom_range(0, 7) == 0);
            d   = $urandom;
            case (r)
                0, 1: begin
                    a = {17'b0, 1'b0, 2'($urandom_range(0, 3)), 12'($urandom_range(0, 15) << 2)};
                    cyc(1, r == 0, a, d, osd, mvd);
                end
                2, 3: begin
                    a = 32'h4000 | 32'($urandom_range(0, 10) << 2);
                    if (a[11:0] == 12'h004 && $urandom_range(0, 1) == 1) d = 0;
                    cyc(1, r == 2, a, d, osd, mvd);
                end
                4, 5: begin
                    a = 32'h5000 | 32'($urandom_range(0, 2) << 2);
                    cyc(1, r == 4, a, 32'($urandom_range(0, 3)), osd, mvd);
                end
                6: begin
                    a = ($urandom_range(0, 1) == 1) ? 32'h6000 : 32'h7004;
                    cyc(1, $urandom_range(0, 1) == 1, a, d, osd, mvd);
                end
                default: cyc(0, 0, 32'h0, 0, osd, mvd);
            endcase
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/npu_host_slave.md
Name: npu_host_slave

Overview:
- Memory-mapped responder for the NPU host bus (cen_i/wen_i/addr_i/wdata_i/rdata_o); it is the target that host firmware and benches drive.
- Decodes the NPU address window into IMEM/WMEM/BMEM/OMEM buffer ports, the parameter register file and the op-launch registers.
- Runs the op-control FSM that launches the OS tile computation and the OS-to-ACT buffer move, and reports busy/done status back to the host.

Parameters:
- DWidth, 32, bus data/address width.
- RAM_AW, 10, word-address width of each buffer RAM.
- REGION_SHIFT, 12, log2 of region size; region select = addr_i[REGION_SHIFT+2:REGION_SHIFT].

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- cen_i  in  1  bus access enable.
- wen_i  in  1  1 = write, 0 = read.
- addr_i  in  DWidth  byte address.
- wdata_i  in  DWidth  write data.
- rdata_o  out  DWidth  read data, registered.
- buf_cen_o  out  4  one-hot buffer select {OMEM,BMEM,WMEM,IMEM}.
- buf_wen_o  out  1  buffer write enable.
- buf_addr_o  out  RAM_AW  word address, addr_i[RAM_AW+1:2].
- buf_wdata_o  out  DWidth  buffer write data.
- imem_rdata_i, wmem_rdata_i, bmem_rdata_i, omem_rdata_i  in  DWidth each  buffer read data, valid 1 cycle after select.
- a_base_o, a_rows_o, w_base_o, w_cols_o, o_base_o, intra_o_base_o, intra_a_base_o  out  DWidth each  parameter registers.
- os_start_o  out  1  1-cycle OS launch pulse.
- mv_start_o  out  1  1-cycle OS-to-ACT move launch pulse.
- os_done_i  in  1  OS completion pulse.
- mv_done_i  in  1  move completion pulse.

Behaviour:
- Region map (sel = addr_i[14:12]):
  - 0 IMEM, 1 WMEM, 2 BMEM, 3 OMEM.
  - 4 PARA.
  - 5 OP.
  - 6-7 unmapped: writes dropped, reads return 0.
- Buffer regions: combinational pass-through of cen/wen/addr/wdata onto the selected buffer port. Read data is muxed by the region latched at the request cycle and registered into rdata_o.
- Read latency: rdata_o is valid exactly 1 cycle after the cen_i=1, wen_i=0 cycle. It holds that value until the next read. Writes do not change rdata_o.
- PARA offsets:
  - 0x04 STATUS: 0 idle, 1 busy, 2 done.
  - 0x08 a_base, 0x0C a_rows, 0x10 w_base, 0x14 w_cols, 0x18 o_base, 0x1C intra_o_base, 0x20 intra_a_base.
  - Other offsets read 0 and ignore writes.
- OP offsets:
  - Write 0x00 with wdata[0]=1 -> launch OS.
  - Write 0x04 with wdata[0]=1 -> launch move.
  - Reads of OP return 0.
- FSM states: IDLE, OS_RUN, MV_RUN, DONE.
  - IDLE: OS launch -> os_start_o=1 next cycle, go to OS_RUN. Move launch -> mv_start_o=1 next cycle, go to MV_RUN.
  - OS_RUN: os_done_i -> DONE. mv_done_i is ignored.
  - MV_RUN: mv_done_i -> DONE. os_done_i is ignored.
  - DONE: a host write of 0 to STATUS -> IDLE. A launch from DONE behaves as from IDLE (implicit clear).
  - STATUS encoding: IDLE=0, OS_RUN/MV_RUN=1, DONE=2.
- Launch writes in OS_RUN/MV_RUN are dropped; no pulse is issued.
- While the FSM is busy:
  - PARA writes are dropped.
  - IMEM/WMEM/BMEM/OMEM writes are blocked (buf_cen_o=0 for writes).
  - Reads of all regions are still served.
- A done pulse and a STATUS clear in the same cycle: the done pulse wins, state becomes DONE.
- Reset (any cycle, including mid-op):
  - FSM -> IDLE.
  - All parameter registers = 0; rdata_o = 0.
  - Start pulses = 0.
  - buf_cen_o = 0.

Optional Feature:
- Macro NPU_PERF_CNT_EN.
- Defined: a DWidth cycle counter clears on the launch pulse and increments each cycle in OS_RUN/MV_RUN. It freezes on entry to DONE and is readable at PARA 0x24. It saturates at all-ones and resets to 0.
- Undefined: no counter logic; PARA 0x24 reads 0.

Test Plan:
- Reset then read PARA 0x04 and 0x08 -> rdata_o=0 one cycle after each read; buf_cen_o=0 throughout.
- Write IMEM+64 = 10, then read it -> buf_cen_o=0001, buf_addr_o=16 on write. Read returns 10 one cycle later.
- Write a_rows=15, w_cols=15, then launch OS -> os_start_o high exactly 1 cycle and STATUS reads 1. Drive os_done_i after 20 cycles -> STATUS=2; write STATUS=0 -> STATUS=0.
- During OS_RUN: write WMEM+8 = 5, write a_base=7, write OP 0x04 = 1 -> no buffer write, a_base stays 0, no mv_start_o.
- From DONE, launch move -> mv_start_o pulse and STATUS=1. Assert rst_ni=0 for 1 cycle mid-op -> STATUS=0 and all parameters 0.
- With NPU_PERF_CNT_EN: OS launch, done after 20 busy cycles -> PARA 0x24 reads 20. Without the macro -> 0.
